// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Contents:
//   fetch_state_e : request FSM states (IDLE, REQ, DISCARD)
//   NOP_INST      : instruction word presented to ID on a bubble
//   INST_BYTES    : PC increment per fetched instruction
//   fifo_entry_t  : buffered fetch result {inst, new_pc}
//   pc_incr       : 32-bit modulo PC+4
//   align_pc      : clears the byte-offset bits of a PC
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] new_pc;
  } fifo_entry_t;

  // Wraps at 2^32, so 32'hFFFF_FFFC advances to 0.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO buffering fetched words ahead of ID
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write push_data_i (ignored when full unless a pop frees a slot)
//   push_data_i   : entry to store
//   pop_i         : remove the head entry (ignored when empty)
//   clear_i       : empty the FIFO; overrides push and pop in the same cycle
//   count_o       : number of stored entries
//   empty_o       : count_o == 0
//   head_o        : oldest entry; only meaningful when empty_o is 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fifo_entry_t                  push_data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output fifo_entry_t                  head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;
  logic          push_ok;
  logic          full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == DEPTH_C);
  assign pop_ok  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign push_ok = push_i && (!full || pop_ok);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC, single-outstanding imem handshake, fetch FIFO, IF/ID register
//
// Optional feature macro: FETCH_PERFCNT_EN adds perf_fetched / perf_bubbles.
//
// Ports:
//   clock, reset     : clock, asynchronous active-low reset
//   imem_req/addr    : fetch request, held with a stable address until imem_ack
//   imem_ack/rdata   : acknowledge with same-cycle instruction word
//   stall            : hold ToID_* and the FIFO head
//   redirect/_pc     : flush the stage and restart fetch at redirect_pc
//   ToID_Inst        : instruction to ID (NOP on a bubble)
//   ToID_NewPC       : fetch PC of ToID_Inst plus 4
//   ToID_Valid       : ToID_Inst is a real instruction
//   perf_fetched     : (FETCH_PERFCNT_EN) instructions popped to ID
//   perf_bubbles     : (FETCH_PERFCNT_EN) unstalled cycles that load a bubble
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ToID_Inst,
  output logic [31:0] ToID_NewPC,
  output logic        ToID_Valid
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int            CW         = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [31:0]   RESET_PC_A = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  newpc_q, newpc_d;
  logic         valid_q, valid_d;

  logic [31:0]  redir_pc;
  logic [31:0]  pc_plus4;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_next;
  logic         has_space;
  fifo_entry_t  push_entry;
  fifo_entry_t  head;

  assign redir_pc = align_pc(redirect_pc);
  assign pc_plus4 = pc_incr(pc_q);

  // In REQ, pc_q is the address of the outstanding request.
  assign fifo_push  = (state_q == REQ) && imem_ack && !redirect;
  assign push_entry = '{inst: imem_rdata, new_pc: pc_plus4};
  assign fifo_pop   = !redirect && !stall && !fifo_empty;

  // Credit is judged on occupancy after this cycle's push/pop/clear, so a
  // new request is only issued when its word is guaranteed a slot.
  assign count_next = redirect ? '0 : (fifo_count + CW'(fifo_push) - CW'(fifo_pop));
  assign has_space  = (count_next < DEPTH_C);

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i       (clock),
    .rst_ni      (reset),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .clear_i     (redirect),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redir_pc;
        end else if (has_space) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d   = redir_pc;
            addr_d = redir_pc;
          end else begin
            pc_d = pc_plus4;
            if (has_space) begin
              addr_d = pc_plus4;
            end else begin
              state_d = IDLE;
              req_d   = 1'b0;
            end
          end
        end else if (redirect) begin
          // Request stays on the bus at the old address until memory answers.
          pc_d    = redir_pc;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect) pc_d = redir_pc;
        if (imem_ack) begin
          state_d = REQ;
          addr_d  = pc_d;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_A;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC_A;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // IF/ID register: redirect beats stall beats pop.
  always_comb begin
    inst_d  = inst_q;
    newpc_d = newpc_q;
    valid_d = valid_q;
    if (redirect) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else if (stall) begin
      inst_d  = inst_q;
    end else if (!fifo_empty) begin
      inst_d  = head.inst;
      newpc_d = head.new_pc;
      valid_d = 1'b1;
    end else begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_q  <= NOP_INST;
      newpc_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      newpc_q <= newpc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ToID_Inst  = inst_q;
  assign ToID_NewPC = newpc_q;
  assign ToID_Valid = valid_q;

`ifdef FETCH_PERFCNT_EN
  logic [31:0] fetched_q;
  logic [31:0] bubbles_q;
  logic        bubble;

  // With stall low the output register always updates, so valid_d=0 is a bubble load.
  assign bubble = !stall && !valid_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_q <= 32'h0;
      bubbles_q <= 32'h0;
    end else begin
      if (fifo_pop) fetched_q <= fetched_q + 32'd1;
      if (bubble)   bubbles_q <= bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (RESET_PC=0x100, BUF_DEPTH=2)
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ToID_Inst;
  logic [31:0] ToID_NewPC;
  logic        ToID_Valid;
`ifdef FETCH_PERFCNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int checks   = 0;
  int failures = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_pc;

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ToID_Inst   (ToID_Inst),
    .ToID_NewPC  (ToID_NewPC),
    .ToID_Valid  (ToID_Valid)
`ifdef FETCH_PERFCNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Memory model: acknowledges once the request has waited ack_delay cycles.
  always @(posedge clock) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hBAD0_BAD0;

  task automatic sb_load(input logic [31:0] start);
    logic [31:0] a;
    sb_q.delete();
    a = start;
    for (int i = 0; i < 48; i++) begin
      sb_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  function automatic logic [31:0] sb_next();
    if (sb_q.size() == 0) return 32'hDEAD_0000;
    return sb_q.pop_front();
  endfunction

  task automatic tick(output logic popped);
    logic st, rd;
    st = stall;
    rd = redirect;
    @(posedge clock);
    #1;
    popped = ToID_Valid && !st && !rd;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    ack_delay = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    sb_load(RST_PC);
  endtask

  task automatic warmup(input int n);
    logic popped;
    for (int i = 0; i < n; i++) begin
      tick(popped);
      if (popped) last_pc = sb_next();
    end
  endtask

  task automatic test_reset();
    logic popped;
    logic [31:0] exp_pc, exp_np;
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_delay = 0;
    @(posedge clock);
    #1;
    checks++;
    if (ToID_Inst !== 32'h0 || ToID_NewPC !== 32'h0 || ToID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_toid: inst=%h newpc=%h valid=%b want 0/0/0", ToID_Inst, ToID_NewPC, ToID_Valid);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_imem: req=%b addr=%h want 0/%h", imem_req, imem_addr, RST_PC);
    end
    @(negedge clock);
    reset = 1'b1;
    sb_load(RST_PC);
    tick(popped);
    checks++;
    if (ToID_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_edge1: valid=%b req=%b addr=%h want 0/1/%h", ToID_Valid, imem_req, imem_addr, RST_PC);
    end
    tick(popped);
    checks++;
    if (ToID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_edge2: valid=%b want 0", ToID_Valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick(popped);
      checks++;
      if (!popped) begin
        failures++;
        $display("FAIL reset_stream_valid: cycle %0d valid=%b want 1", i + 3, ToID_Valid);
      end else begin
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        last_pc = exp_pc;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL reset_stream: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic popped;
    logic [31:0] exp_pc, exp_np;
    apply_reset();
    warmup(5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(popped);
      exp_np = last_pc + 32'd4;
      checks++;
      if (ToID_Valid !== 1'b1 || ToID_NewPC !== exp_np || ToID_Inst !== mem_word(last_pc)) begin
        failures++;
        $display("FAIL stall_hold: valid=%b newpc=%h inst=%h want 1/%h/%h", ToID_Valid, ToID_NewPC, ToID_Inst, exp_np, mem_word(last_pc));
      end
    end
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_req: req=%b want 0", imem_req);
    end
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(popped);
      checks++;
      if (!popped) begin
        failures++;
        $display("FAIL stall_release_gap: cycle %0d valid=%b want 1", i, ToID_Valid);
      end else begin
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL stall_release: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
  endtask

  task automatic test_redirect_discard();
    logic popped;
    logic found;
    int npops;
    logic [31:0] exp_pc, exp_np;
    apply_reset();
    warmup(5);
    checks++;
    if (imem_addr !== 32'h110) begin
      failures++;
      $display("FAIL discard_pre_addr: addr=%h want 00000110", imem_addr);
    end
    ack_delay = 4;
    redirect = 1'b1;
    redirect_pc = 32'h400;
    tick(popped);
    redirect = 1'b0;
    sb_load(32'h400);
    checks++;
    if (ToID_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h110) begin
      failures++;
      $display("FAIL discard_enter: valid=%b req=%b addr=%h want 0/1/00000110", ToID_Valid, imem_req, imem_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(popped);
      checks++;
      if (ToID_Valid !== 1'b0) begin
        failures++;
        $display("FAIL discard_leak: valid=%b newpc=%h want valid 0", ToID_Valid, ToID_NewPC);
      end
      if (imem_addr === 32'h400) begin
        found = 1'b1;
      end else begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin
          failures++;
          $display("FAIL discard_hold: req=%b addr=%h want 1/00000110", imem_req, imem_addr);
        end
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL discard_timeout: addr=%h want 00000400 within 20 cycles", imem_addr);
    end
    ack_delay = 0;
    npops = 0;
    for (int i = 0; i < 6; i++) begin
      tick(popped);
      if (popped) begin
        npops++;
        checks++;
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL discard_stream: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
    checks++;
    if (npops < 3) begin
      failures++;
      $display("FAIL discard_pops: got %0d want at least 3", npops);
    end
  endtask

  task automatic test_redirect_stall();
    logic popped;
    int npops;
    logic [31:0] exp_pc, exp_np;
    apply_reset();
    warmup(5);
    stall = 1'b1;
    tick(popped);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick(popped);
    redirect = 1'b0;
    stall = 1'b0;
    sb_load(32'h200);
    checks++;
    if (ToID_Valid !== 1'b0 || ToID_Inst !== 32'h0) begin
      failures++;
      $display("FAIL redir_stall_out: valid=%b inst=%h want 0/00000000", ToID_Valid, ToID_Inst);
    end
    tick(popped);
    checks++;
    if (ToID_Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL redir_stall_flush: valid=%b req=%b addr=%h want 0/1/00000200", ToID_Valid, imem_req, imem_addr);
    end
    npops = 0;
    for (int i = 0; i < 6; i++) begin
      tick(popped);
      if (popped) begin
        npops++;
        checks++;
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL redir_stall_stream: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
    checks++;
    if (npops < 3) begin
      failures++;
      $display("FAIL redir_stall_pops: got %0d want at least 3", npops);
    end
  endtask

  task automatic test_wrap();
    logic popped;
    int npops;
    logic [31:0] exp_pc, exp_np;
    apply_reset();
    warmup(5);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick(popped);
    redirect = 1'b0;
    sb_load(32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || ToID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_addr: addr=%h valid=%b want fffffffc/0", imem_addr, ToID_Valid);
    end
    tick(popped);
    checks++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL wrap_next_addr: addr=%h req=%b want 00000000/1", imem_addr, imem_req);
    end
    npops = 0;
    for (int i = 0; i < 4; i++) begin
      tick(popped);
      if (popped) begin
        npops++;
        checks++;
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL wrap_stream: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
    checks++;
    if (npops < 3) begin
      failures++;
      $display("FAIL wrap_pops: got %0d want at least 3", npops);
    end
  endtask

  task automatic test_reset_mid_req();
    logic popped;
    int npops;
    logic [31:0] exp_pc, exp_np;
    apply_reset();
    warmup(5);
    ack_delay = 3;
    tick(popped);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin
      failures++;
      $display("FAIL midreq_pending: req=%b addr=%h want 1/00000110", imem_req, imem_addr);
    end
`ifdef FETCH_PERFCNT_EN
    checks++;
    if (perf_fetched !== 32'd4 || perf_bubbles !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts: fetched=%0d bubbles=%0d want 4/2", perf_fetched, perf_bubbles);
    end
`endif
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RST_PC || ToID_Valid !== 1'b0) begin
      failures++;
      $display("FAIL midreq_reset: req=%b addr=%h valid=%b want 0/%h/0", imem_req, imem_addr, ToID_Valid, RST_PC);
    end
`ifdef FETCH_PERFCNT_EN
    checks++;
    if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: fetched=%0d bubbles=%0d want 0/0", perf_fetched, perf_bubbles);
    end
`endif
    ack_delay = 0;
    @(negedge clock);
    reset = 1'b1;
    sb_load(RST_PC);
    npops = 0;
    for (int i = 0; i < 6; i++) begin
      tick(popped);
      if (popped) begin
        npops++;
        checks++;
        exp_pc = sb_next();
        exp_np = exp_pc + 32'd4;
        if (ToID_NewPC !== exp_np || ToID_Inst !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL midreq_restart: inst=%h newpc=%h want inst=%h newpc=%h", ToID_Inst, ToID_NewPC, mem_word(exp_pc), exp_np);
        end
      end
    end
    checks++;
    if (npops < 3) begin
      failures++;
      $display("FAIL midreq_pops: got %0d want at least 3", npops);
    end
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    last_pc = 32'h0;
    test_reset();
    test_stall();
    test_redirect_discard();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
